// File: rtl/ddr_xfer_sched_pkg.sv
// Shared definitions for the DDR transfer scheduler: descriptor field layout,
// FSM state encoding and burst geometry.
package ddr_xfer_sched_pkg;

  localparam int ADDR_LSB        = 0;
  localparam int ADDR_W          = 32;
  localparam int NLAST_LSB       = 32;
  localparam int NLAST_W         = 7;
  localparam int NBURSTS_LSB     = 39;
  localparam int NBURSTS_W       = 18;
  localparam int BYTES_PER_BURST = 128;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_INCR   = 3'd3,
    ST_ISSUE  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_FIN    = 3'd6
  } state_t;

  function automatic logic [NBURSTS_W-1:0] cfg_nbursts(input logic [63:0] cfg);
    return cfg[NBURSTS_LSB +: NBURSTS_W];
  endfunction

endpackage

// File: rtl/ddr_xfer_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// The pointer itself is owned and registered by the parent.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  localparam logic [PTR_W:0] N_V = (PTR_W+1)'(N);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= N_V) sum = sum - N_V;
      idx = sum[PTR_W-1:0];
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_xfer_sched.sv
// Round-robin owner of one DDR address generator + burst mover: latches the
// granted descriptor, steps it chunk by chunk and reports completion.
module ddr_xfer_sched
  import ddr_xfer_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int UNIT_BURSTS = 128,
  parameter int CFG_W       = 64,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*CFG_W-1:0] req_cfg,
  output logic [N_REQ-1:0]       req_grant,
  output logic [N_REQ-1:0]       req_done,
  output logic [CFG_W-1:0]       ag_cfg,
  output logic                   ag_latch_en,
  output logic                   ag_incr_en,
  input  logic [31:0]            ag_addr,
  input  logic [31:0]            ag_nbursts,
  input  logic                   ag_pending,
  input  logic                   ag_done,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [31:0]            cmd_addr,
  output logic [31:0]            cmd_nbursts,
  input  logic                   cmd_done,
  output logic                   busy,
  output logic [CNT_W-1:0]       chunk_cnt,
  output state_t                 dbg_state
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, owner_idx, arb_idx;
  logic [N_REQ-1:0] arb_grant;
  logic             arb_valid;
  logic [CFG_W-1:0] cfg_sel;
  logic             done_seen;
  logic             cmd_hs;

  // cmd channel: payload is stable while cmd_valid is high; a transfer happens
  // on any cycle with cmd_valid && cmd_ready, after which cmd_valid drops.
  assign cmd_hs = cmd_valid & cmd_ready;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    cfg_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        arb_idx = PTR_W'(i);
        cfg_sel = req_cfg[i*CFG_W +: CFG_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (arb_valid) state_nxt = ST_LATCH;
      ST_LATCH:  state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ag_done ? ST_FIN : ST_INCR;
      ST_INCR:   state_nxt = ST_ISSUE;
      ST_ISSUE:  if (cmd_hs) state_nxt = ST_WAIT;
      ST_WAIT:   if (done_seen && !ag_pending) state_nxt = ag_done ? ST_FIN : ST_INCR;
      ST_FIN:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ag_latch_en = 1'b0;
    ag_incr_en  = 1'b0;
    req_done    = '0;
    case (state)
      ST_LATCH: ag_latch_en = 1'b1;
      ST_INCR:  ag_incr_en  = 1'b1;
      ST_FIN:   req_done    = req_grant;
      default:  ;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_grant <= '0;
      owner_idx <= '0;
      ag_cfg    <= '0;
      rr_ptr    <= '0;
    end else if (state == ST_IDLE && arb_valid) begin
      req_grant <= arb_grant;
      owner_idx <= arb_idx;
      ag_cfg    <= cfg_sel;
    end else if (state == ST_FIN) begin
      req_grant <= '0;
      rr_ptr    <= (owner_idx == PTR_W'(N_REQ-1)) ? '0 : owner_idx + PTR_W'(1);
    end
  end

  // Payload is captured in the first ISSUE cycle, when the generator has
  // settled on the chunk stepped by the preceding INCR.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_nbursts <= '0;
    end else if (state == ST_ISSUE) begin
      if (!cmd_valid) begin
        cmd_valid   <= 1'b1;
        cmd_addr    <= ag_addr;
        cmd_nbursts <= ag_nbursts;
      end else if (cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      chunk_cnt <= '0;
    else if ((state == ST_IDLE && arb_valid) || state == ST_LATCH)
      chunk_cnt <= '0;
    else if (cmd_hs && chunk_cnt != '1)
      chunk_cnt <= chunk_cnt + CNT_W'(1);
  end

  // A cmd_done coinciding with the handshake must not be lost.
  always_ff @(posedge clk) begin
    if (rst)
      done_seen <= 1'b0;
    else if (state == ST_ISSUE)
      done_seen <= cmd_hs & cmd_done;
    else if (state == ST_WAIT)
      done_seen <= (state_nxt == ST_WAIT) ? (done_seen | cmd_done) : 1'b0;
    else
      done_seen <= 1'b0;
  end

  a_chunk_size: assert property (@(posedge clk) disable iff (rst)
    cmd_valid |-> (cmd_nbursts <= 32'(UNIT_BURSTS)));

  a_zero_desc: assert property (@(posedge clk) disable iff (rst)
    (state == ST_SETTLE) |-> (ag_done == (cfg_nbursts(64'(ag_cfg)) == '0)));

endmodule

// File: tb/tb_ddr_xfer_sched.sv
// Directed bench for ddr_xfer_sched with a behavioural address generator and
// burst mover whose handshake/done/pending timing is set per transfer.
module tb_ddr_xfer_sched;
  import ddr_xfer_sched_pkg::*;

  localparam int N_REQ = 4;
  localparam int CFG_W = 64;
  localparam int CNT_W = 16;
  localparam int UNIT  = 128;

  logic                   clk, rst;
  logic [N_REQ-1:0]       req_valid, req_grant, req_done;
  logic [N_REQ*CFG_W-1:0] req_cfg;
  logic [CFG_W-1:0]       ag_cfg;
  logic                   ag_latch_en, ag_incr_en;
  logic [31:0]            ag_addr, ag_nbursts;
  logic                   ag_pending, ag_done;
  logic                   cmd_valid, cmd_ready, cmd_done;
  logic [31:0]            cmd_addr, cmd_nbursts;
  logic                   busy;
  logic [CNT_W-1:0]       chunk_cnt;
  state_t                 dbg_state;

  ddr_xfer_sched #(.N_REQ(N_REQ), .UNIT_BURSTS(UNIT), .CFG_W(CFG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cfg(req_cfg),
    .req_grant(req_grant), .req_done(req_done), .ag_cfg(ag_cfg),
    .ag_latch_en(ag_latch_en), .ag_incr_en(ag_incr_en), .ag_addr(ag_addr),
    .ag_nbursts(ag_nbursts), .ag_pending(ag_pending), .ag_done(ag_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_nbursts(cmd_nbursts), .cmd_done(cmd_done), .busy(busy),
    .chunk_cnt(chunk_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] chunk_of(input logic [17:0] rem);
    return (rem > 18'(UNIT)) ? 18'(UNIT) : rem;
  endfunction

  function automatic logic [CFG_W-1:0] make_cfg(input logic [31:0] a, input int nb);
    logic [CFG_W-1:0] c;
    c = '0;
    c[ADDR_LSB +: ADDR_W]       = a;
    c[NLAST_LSB +: NLAST_W]     = 7'h40;
    c[NBURSTS_LSB +: NBURSTS_W] = NBURSTS_W'(nb);
    return c;
  endfunction

  // ---------------- address generator model ----------------
  logic [31:0] ag_cur;
  logic [17:0] ag_rem;
  assign ag_done = (ag_rem == '0);

  always @(posedge clk) begin
    if (rst) begin
      ag_cur <= '0; ag_rem <= '0; ag_addr <= '0; ag_nbursts <= '0;
    end else if (ag_latch_en) begin
      ag_cur <= ag_cfg[ADDR_LSB +: ADDR_W];
      ag_rem <= ag_cfg[NBURSTS_LSB +: NBURSTS_W];
    end else if (ag_incr_en) begin
      ag_addr    <= ag_cur;
      ag_nbursts <= 32'(chunk_of(ag_rem));
      ag_cur     <= ag_cur + 32'(chunk_of(ag_rem)) * 32'(BYTES_PER_BURST);
      ag_rem     <= ag_rem - chunk_of(ag_rem);
    end
  end

  // ---------------- burst mover model ----------------
  int   ready_hold = 0;
  int   done_lat   = 1;
  int   pend_len   = 0;
  int   vcnt, scnt;
  logic active;

  assign cmd_ready  = cmd_valid && (vcnt >= ready_hold);
  assign cmd_done   = (cmd_valid && cmd_ready && done_lat == 0) ||
                      (active && done_lat != 0 && scnt == done_lat);
  assign ag_pending = active && (scnt <= pend_len);

  always @(posedge clk) begin
    if (rst) begin
      vcnt <= 0; scnt <= 0; active <= 1'b0;
    end else begin
      vcnt <= (cmd_valid && !cmd_ready) ? vcnt + 1 : 0;
      if (cmd_valid && cmd_ready) begin
        active <= 1'b1;
        scnt   <= 1;
      end else if (active) begin
        scnt <= scnt + 1;
        if (scnt >= done_lat && scnt >= pend_len) active <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard / protocol monitor ----------------
  logic        prev_stall, prev_pend, outstanding, done_obs;
  logic [63:0] prev_pl;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0; prev_pend = 1'b0; outstanding = 1'b0; done_obs = 1'b0;
    end else begin
      if (cmd_valid && prev_stall) chk("cmd_stable", {cmd_addr, cmd_nbursts}, prev_pl);
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) chk("cmd_unexpected", 64'(exp_q.size()), 64'd1);
        else                   chk("cmd_payload", {cmd_addr, cmd_nbursts}, exp_q.pop_front());
        outstanding = 1'b1;
        done_obs    = cmd_done;
      end else if (cmd_done && outstanding) begin
        done_obs = 1'b1;
      end
      if (ag_incr_en) begin
        chk("incr_legal", 64'(!outstanding || (done_obs && !prev_pend)), 64'd1);
        outstanding = 1'b0;
        done_obs    = 1'b0;
      end
      if (req_done != '0) outstanding = 1'b0;
      prev_stall = cmd_valid && !cmd_ready;
      prev_pl    = {cmd_addr, cmd_nbursts};
      prev_pend  = ag_pending;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_outputs_zero();
    chk("rst_grant",    64'(req_grant), 64'd0);
    chk("rst_done",     64'(req_done), 64'd0);
    chk("rst_ag_cfg",   64'(ag_cfg), 64'd0);
    chk("rst_ctrl",     64'({ag_latch_en, ag_incr_en, cmd_valid, busy}), 64'd0);
    chk("rst_cmd",      {cmd_addr, cmd_nbursts}, 64'd0);
    chk("rst_chunk",    64'(chunk_cnt), 64'd0);
    chk("rst_state",    64'(dbg_state), 64'(ST_IDLE));
  endtask

  task automatic do_xfer(input int r, input logic [31:0] addr, input int nb, input int rh,
                         input int dl, input int pl, input int exp_chunks, input int max_lat,
                         input logic [N_REQ-1:0] others);
    logic [CFG_W-1:0] cfg;
    logic [N_REQ-1:0] one_r;
    logic [31:0]      a;
    int rem, n, cyc, d_cyc, lat, inc, val, hs;
    bit done_flag;
    ready_hold = rh; done_lat = dl; pend_len = pl;
    rem = nb; a = addr;
    while (rem > 0) begin
      n = (rem > UNIT) ? UNIT : rem;
      exp_q.push_back({a, 32'(n)});
      a   = a + 32'(n * BYTES_PER_BURST);
      rem = rem - n;
    end
    cfg   = make_cfg(addr, nb);
    one_r = N_REQ'(1) << r;
    req_cfg[r*CFG_W +: CFG_W] = cfg;
    req_valid = req_valid | others | one_r;
    @(negedge clk);
    chk("grant", 64'(req_grant), 64'(one_r));
    chk("ag_cfg", 64'(ag_cfg), 64'(cfg));
    chk("chunk_cnt_clr", 64'(chunk_cnt), 64'd0);
    req_valid = req_valid & ~others;
    lat = 0; inc = 0; val = 0; hs = 0; cyc = 0; d_cyc = 0; done_flag = 1'b0;
    while (!done_flag && cyc < 3000) begin
      if (ag_latch_en) lat++;
      if (ag_incr_en)  inc++;
      if (cmd_valid)   val++;
      if (cmd_valid && cmd_ready) hs++;
      if (req_done != '0) begin
        done_flag = 1'b1;
        d_cyc     = cyc;
        chk("done_owner", 64'(req_done), 64'(one_r));
        chk("chunk_cnt_fin", 64'(chunk_cnt), 64'(exp_chunks));
        req_valid[r] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (!done_flag) chk("xfer_timeout", 64'd0, 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    chk("grant_after", 64'(req_grant), 64'd0);
    chk("done_one_cycle", 64'(req_done), 64'd0);
    chk("latch_cnt", 64'(lat), 64'd1);
    chk("incr_cnt", 64'(inc), 64'(exp_chunks));
    chk("hs_cnt", 64'(hs), 64'(exp_chunks));
    chk("valid_cycles", 64'(val), 64'(exp_chunks * (rh + 1)));
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    if (max_lat > 0) chk("done_latency", 64'(d_cyc <= max_lat), 64'd1);
  endtask

  typedef struct {
    int          r;
    logic [31:0] addr;
    int          nb;
    int          rh;
    int          dl;
    int          pl;
    int          exp_chunks;
    int          max_lat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [N_REQ-1:0] g_ord[8];
    logic [N_REQ-1:0] d_ord[8];
    logic [N_REQ-1:0] prev_g;
    logic [31:0]      fa;
    int n_g, n_d, cyc;

    //        req addr           nb   rh  dl pl chunks maxlat
    tbl[0] = '{0, 32'h1000_0000, 300, 0,  2, 0, 3, 0};
    tbl[1] = '{1, 32'h1100_0000, 128, 0,  1, 0, 1, 0};
    tbl[2] = '{3, 32'h1200_0080, 129, 2,  3, 1, 2, 0};
    tbl[3] = '{0, 32'h1300_0000, 0,   0,  1, 0, 0, 4};
    tbl[4] = '{1, 32'h1400_0000, 1,   10, 1, 0, 1, 0};
    tbl[5] = '{3, 32'h1500_0000, 200, 0,  0, 5, 2, 0};
    tbl[6] = '{2, 32'h1600_0000, 2,   1,  3, 8, 1, 0};

    rst = 1'b1; req_valid = '0; req_cfg = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero();
    rst = 1'b0;
    @(negedge clk);

    // All four requesters at once from pointer 0.
    for (int i = 0; i < N_REQ; i++) begin
      fa = 32'h2000_0000 + 32'(i * 'h100);
      req_cfg[i*CFG_W +: CFG_W] = make_cfg(fa, 1);
      exp_q.push_back({fa, 32'd1});
    end
    ready_hold = 0; done_lat = 1; pend_len = 0;
    req_valid = '1; n_g = 0; n_d = 0; prev_g = '0; cyc = 0;
    while (n_d < N_REQ && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (req_grant != '0 && prev_g == '0 && n_g < 8) begin g_ord[n_g] = req_grant; n_g++; end
      if (req_done != '0 && n_d < 8) begin
        d_ord[n_d] = req_done; n_d++;
        req_valid = req_valid & ~req_done;
      end
      prev_g = req_grant;
    end
    chk("rr_grants", 64'(n_g), 64'(N_REQ));
    chk("rr_dones", 64'(n_d), 64'(N_REQ));
    for (int k = 0; k < N_REQ; k++) begin
      if (k < n_g) chk("rr_grant_order", 64'(g_ord[k]), 64'(N_REQ'(1) << k));
      if (k < n_d) chk("rr_done_order", 64'(d_ord[k]), 64'(N_REQ'(1) << k));
    end
    @(negedge clk);
    chk("rr_busy_after", 64'(busy), 64'd0);

    for (int t = 0; t < 7; t++)
      do_xfer(tbl[t].r, tbl[t].addr, tbl[t].nb, tbl[t].rh, tbl[t].dl, tbl[t].pl,
              tbl[t].exp_chunks, tbl[t].max_lat, '0);

    // Reset while a 300-burst transfer sits in WAIT.
    ready_hold = 0; done_lat = 30; pend_len = 0;
    req_cfg[3*CFG_W +: CFG_W] = make_cfg(32'h3000_0000, 300);
    exp_q.push_back({32'h3000_0000, 32'd128});
    req_valid[3] = 1'b1;
    cyc = 0;
    while (!(cmd_valid && cmd_ready) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_hs_seen", 64'(cmd_valid && cmd_ready), 64'd1);
    repeat (3) @(negedge clk);
    chk("state_wait", 64'(dbg_state), 64'(ST_WAIT));
    chk("grant_before_rst", 64'(req_grant), 64'h8);
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    chk_outputs_zero();
    rst = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_rst", 64'({req_done, busy}), 64'd0);
    end
    // Requesters 2 and 3 both valid: pointer 0 must pick 2.
    req_cfg[3*CFG_W +: CFG_W] = make_cfg(32'h3100_0000, 1);
    do_xfer(2, 32'h3400_0000, 1, 0, 1, 0, 1, 0, 4'b1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
